// File: rtl/crforth_pkg.sv
// Types shared by the phase sequencer, the CPU datapath and the debug unit.
package crforth_pkg;

    // Instruction phase; also the encoding presented on o_PHASE.
    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_X    = 2'd1,
        PH_Y    = 2'd2,
        PH_Z    = 2'd3
    } phase_t;

endpackage

// File: rtl/phase_sequencer_wait_timer.sv
// Counts consecutive stalled cycles in one phase. expire fires on a stalled
// cycle that arrives after WAIT_MAX stalls have already been absorbed.
module wait_timer #(
    parameter int WAIT_W   = 8,
    parameter int WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_MAX);

    logic [WAIT_W-1:0] count;

    assign expire = enable & (count == LIMIT);

    // Stall counter: restarts whenever the phase is not stalled or the limit trips.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Single-clock X/Y/Z phase sequencer with run/halt/single-step control,
// memory wait-state stalls and a sticky stall timeout.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  PH_IDLE | halted; waits for run or step (never leaves after timeout)
//  PH_X    | phase X; strobes o_CYCLEX when not stalled
//  PH_Y    | phase Y; strobes o_CYCLEY when not stalled
//  PH_Z    | phase Z; strobes o_CYCLEZ, retires the instruction
module phase_sequencer
    import crforth_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 255,
    parameter int WAIT_W   = 8
) (
    input  logic             i_CLOCK,
    input  logic             i_RESET,
    input  logic             i_RUN,
    input  logic             i_STEP,
    input  logic             i_HALT_REQ,
    input  logic             i_WAIT,
    output logic             o_CYCLEX,
    output logic             o_CYCLEY,
    output logic             o_CYCLEZ,
    output logic [1:0]       o_PHASE,
    output logic             o_HALTED,
    output logic             o_TIMEOUT,
    output logic [CNT_W-1:0] o_INSTR_COUNT
);

    phase_t state;
    phase_t state_nxt;
    logic   halt_pend;
    logic   halt_pend_nxt;
    logic   step_mode;
    logic   step_mode_nxt;
    logic   timeout_nxt;
    logic   retire;
    logic   stalled;
    logic   expire;

    // Stalls only count while an instruction is in flight; IDLE ignores i_WAIT.
    assign stalled = (state != PH_IDLE) & i_WAIT;

    wait_timer #(
        .WAIT_W   (WAIT_W),
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk    (i_CLOCK),
        .rst    (i_RESET),
        .clear  (~stalled),
        .enable (stalled),
        .expire (expire)
    );

    // Strobes are combinational so a stall or reset removes them in the same cycle.
    assign o_CYCLEX = (state == PH_X) & ~i_WAIT;
    assign o_CYCLEY = (state == PH_Y) & ~i_WAIT;
    assign o_CYCLEZ = (state == PH_Z) & ~i_WAIT;
    assign o_PHASE  = state;
    assign o_HALTED = (state == PH_IDLE);

    // Next-state and control-flag logic.
    always_comb begin
        state_nxt     = state;
        halt_pend_nxt = halt_pend;
        step_mode_nxt = step_mode;
        timeout_nxt   = o_TIMEOUT;
        retire        = 1'b0;

        if ((state != PH_IDLE) && i_HALT_REQ) begin
            halt_pend_nxt = 1'b1;
        end

        if (state == PH_IDLE) begin
            if (!o_TIMEOUT && !i_HALT_REQ) begin
                if (i_RUN) begin
                    state_nxt     = PH_X;
                    step_mode_nxt = 1'b0;
                end else if (i_STEP) begin
                    state_nxt     = PH_X;
                    step_mode_nxt = 1'b1;
                end
            end
        end else if (expire) begin
            // Abandon the instruction: no strobe, nothing retired, locked until reset.
            state_nxt   = PH_IDLE;
            timeout_nxt = 1'b1;
        end else if (!i_WAIT) begin
            if (state == PH_X) begin
                state_nxt = PH_Y;
            end else if (state == PH_Y) begin
                state_nxt = PH_Z;
            end else begin
                retire = 1'b1;
                // A halt request landing in the Z cycle itself still stops here.
                if (halt_pend || i_HALT_REQ || step_mode || !i_RUN) begin
                    state_nxt     = PH_IDLE;
                    halt_pend_nxt = 1'b0;
                    step_mode_nxt = 1'b0;
                end else begin
                    state_nxt = PH_X;
                end
            end
        end
    end

    // State register and control flags.
    always_ff @(posedge i_CLOCK or posedge i_RESET) begin
        if (i_RESET) begin
            state     <= PH_IDLE;
            halt_pend <= 1'b0;
            step_mode <= 1'b0;
            o_TIMEOUT <= 1'b0;
        end else begin
            state     <= state_nxt;
            halt_pend <= halt_pend_nxt;
            step_mode <= step_mode_nxt;
            o_TIMEOUT <= timeout_nxt;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge i_CLOCK or posedge i_RESET) begin
        if (i_RESET) begin
            o_INSTR_COUNT <= '0;
        end else if (retire) begin
            o_INSTR_COUNT <= o_INSTR_COUNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_phase_sequencer;

    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 4;
    localparam int WAIT_W   = 3;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             run      = 1'b0;
    logic             step     = 1'b0;
    logic             halt_req = 1'b0;
    logic             stall    = 1'b0;
    logic             cyc_x;
    logic             cyc_y;
    logic             cyc_z;
    logic [1:0]       phase;
    logic             halted;
    logic             timeout;
    logic [CNT_W-1:0] icount;

    int errors = 0;
    int checks = 0;

    // Model state: phase as 0..3, stall run length, sticky flags, retired count.
    int m_ph   = 0;
    int m_wait = 0;
    int m_cnt  = 0;
    bit m_hp   = 1'b0;
    bit m_step = 1'b0;
    bit m_to   = 1'b0;

    phase_sequencer #(
        .CNT_W    (CNT_W),
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) dut (
        .i_CLOCK       (clk),
        .i_RESET       (rst),
        .i_RUN         (run),
        .i_STEP        (step),
        .i_HALT_REQ    (halt_req),
        .i_WAIT        (stall),
        .o_CYCLEX      (cyc_x),
        .o_CYCLEY      (cyc_y),
        .o_CYCLEZ      (cyc_z),
        .o_PHASE       (phase),
        .o_HALTED      (halted),
        .o_TIMEOUT     (timeout),
        .o_INSTR_COUNT (icount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: instruction = three phases, stalls stretch a phase,
    // more than WAIT_MAX stalls in a row kills the sequencer until reset.
    always @(posedge clk or posedge rst) begin
        int ph;
        int w;
        int c;
        bit hp;
        bit st;
        bit to;
        if (rst) begin
            m_ph   <= 0;
            m_wait <= 0;
            m_cnt  <= 0;
            m_hp   <= 1'b0;
            m_step <= 1'b0;
            m_to   <= 1'b0;
        end else begin
            ph = m_ph; w = m_wait; c = m_cnt; hp = m_hp; st = m_step; to = m_to;
            if (ph == 0) begin
                if (!to && !halt_req && (run || step)) begin
                    ph = 1;
                    st = !run;
                end
            end else if (stall) begin
                if (halt_req) hp = 1'b1;
                if (w == WAIT_MAX) begin
                    to = 1'b1;
                    ph = 0;
                    w  = 0;
                end else begin
                    w = w + 1;
                end
            end else begin
                w = 0;
                if (ph < 3) begin
                    ph = ph + 1;
                    if (halt_req) hp = 1'b1;
                end else begin
                    c = (c + 1) % (1 << CNT_W);
                    if (hp || halt_req || st || !run) begin
                        ph = 0;
                        hp = 1'b0;
                        st = 1'b0;
                    end else begin
                        ph = 1;
                    end
                end
            end
            m_ph <= ph; m_wait <= w; m_cnt <= c; m_hp <= hp; m_step <= st; m_to <= to;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cycle_x", cyc_x, (m_ph == 1) && !stall);
            chk("cycle_y", cyc_y, (m_ph == 2) && !stall);
            chk("cycle_z", cyc_z, (m_ph == 3) && !stall);
            chk("phase",   phase, m_ph);
            chk("halted",  halted, m_ph == 0);
            chk("timeout", timeout, m_to);
            chk("count",   icount, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        run = 1'b0; step = 1'b0; halt_req = 1'b0; stall = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] pat [3];
        int burst;
        bit in_rst;
        pat[0] = 3'b100; pat[1] = 3'b010; pat[2] = 3'b001;

        // Reset state
        do_reset();
        chk("rst_halted", halted, 1);
        chk("rst_phase", phase, 0);
        chk("rst_strobes", {cyc_x, cyc_y, cyc_z}, 0);
        chk("rst_count", icount, 0);
        chk("rst_timeout", timeout, 0);

        // Free run: X,Y,Z x3 from the first cycle, no bubble
        run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("run_strobe", {cyc_x, cyc_y, cyc_z}, pat[i % 3]);
        end
        run = 1'b0;
        tick();
        chk("run_halted", halted, 1);
        chk("run_count", icount, 3);

        // Single step, twice
        do_reset();
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step_x", cyc_x, 1);
        tick();
        chk("step_y", cyc_y, 1);
        tick();
        chk("step_z", cyc_z, 1);
        tick();
        chk("step_halted", halted, 1);
        chk("step_count1", icount, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        tick();
        chk("step_count2", icount, 2);
        chk("step_halted2", halted, 1);

        // Halt request in Y completes the instruction
        do_reset();
        run = 1'b1;
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("halt_z", cyc_z, 1);
        tick();
        chk("halt_halted", halted, 1);
        chk("halt_count", icount, 1);
        run = 1'b0;
        tick();

        // Three wait states in Y
        do_reset();
        run = 1'b1;
        tick();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wait_phase", phase, 2);
            chk("wait_nostrobe", cyc_y, 0);
            tick();
        end
        stall = 1'b0;
        #1;
        chk("wait_y", cyc_y, 1);
        run = 1'b0;
        tick();
        chk("wait_z", cyc_z, 1);
        tick();
        chk("wait_count", icount, 1);

        // Timeout stuck in X
        do_reset();
        run = 1'b1;
        stall = 1'b1;
        tick();
        for (int k = 0; k < WAIT_MAX; k++) begin
            tick();
            chk("to_hold_phase", phase, 1);
            chk("to_not_yet", timeout, 0);
        end
        tick();
        chk("to_flag", timeout, 1);
        chk("to_halted", halted, 1);
        chk("to_nostrobe", cyc_x, 0);
        stall = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (5) tick();
        chk("to_locked", halted, 1);
        chk("to_count", icount, 0);

        // 17 instructions wrap a 4-bit count to 1; run drops mid-instruction
        do_reset();
        run = 1'b1;
        repeat (50) tick();
        run = 1'b0;
        tick();
        chk("wrap_z", cyc_z, 1);
        tick();
        chk("wrap_halted", halted, 1);
        chk("wrap_count", icount, 1);

        // Asynchronous reset in the middle of Y
        run = 1'b1;
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        chk("arst_strobes", {cyc_x, cyc_y, cyc_z}, 0);
        chk("arst_phase", phase, 0);
        chk("arst_halted", halted, 1);
        chk("arst_count", icount, 0);
        run = 1'b0;
        tick();
        rst = 1'b0;

        // Randomized traffic against the model
        burst = 0;
        in_rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (in_rst) begin
                rst = 1'b0;
                in_rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                in_rst = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) run = ~run;
            step     = ($urandom_range(0, 7) == 0);
            halt_req = ($urandom_range(0, 14) == 0);
            if (burst > 0) begin
                stall = 1'b1;
                burst--;
            end else if ($urandom_range(0, 59) == 0) begin
                burst = WAIT_MAX + 2;
                stall = 1'b1;
            end else begin
                stall = ($urandom_range(0, 3) == 0);
            end
        end
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
